// File: rtl/cache_req_arbiter.sv
// Round-robin front end sharing one cache controller port between a fetch and a load/store requester.
// One transaction in flight at a time; a WAIT-state timeout returns an error response.
module cache_req_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic              req0_hit,
    output logic              req0_err,

    input  logic              req1_valid,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic              req1_hit,
    output logic              req1_err,

    output logic [DATA_W-1:0] rd_data,

    output logic              c_rd_en,
    output logic              c_wr_en,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_wr_data,
    input  logic              c_done,
    input  logic              c_hit,
    input  logic [DATA_W-1:0] c_rd_data
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              id_q, id_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              hit_q, hit_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic win_valid;
    logic win_id;
    logic is_idle;
    logic is_resp;

    assign is_idle   = (state_q == StIdle);
    assign is_resp   = (state_q == StResp);
    assign win_valid = req0_valid | req1_valid;
    // On a tie the requester that did not win last time gets the grant.
    assign win_id    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        hit_d        = hit_q;
        err_d        = err_q;
        data_d       = data_q;
        case (state_q)
            StIdle: begin
                if (win_valid) begin
                    id_d         = win_id;
                    last_grant_d = win_id;
                    wr_d         = win_id ? req1_wr    : req0_wr;
                    addr_d       = win_id ? req1_addr  : req0_addr;
                    wdata_d      = win_id ? req1_wdata : req0_wdata;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // Completion on the terminal count beats the timeout.
                if (c_done) begin
                    hit_d   = c_hit;
                    err_d   = 1'b0;
                    data_d  = wr_q ? '0 : c_rd_data;
                    state_d = StResp;
                end else if (cnt_q == CntLast) begin
                    hit_d   = 1'b0;
                    err_d   = 1'b1;
                    data_d  = '0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            hit_q        <= 1'b0;
            err_q        <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            hit_q        <= hit_d;
            err_q        <= err_d;
            data_q       <= data_d;
        end
    end

    always_comb begin
        req0_ready  = is_idle && win_valid && !win_id;
        req1_ready  = is_idle && win_valid &&  win_id;
        req0_rvalid = is_resp && !id_q;
        req1_rvalid = is_resp &&  id_q;
        req0_hit    = req0_rvalid && hit_q;
        req0_err    = req0_rvalid && err_q;
        req1_hit    = req1_rvalid && hit_q;
        req1_err    = req1_rvalid && err_q;
        rd_data     = is_resp ? data_q : '0;
        c_rd_en     = (state_q == StIssue) && !wr_q;
        c_wr_en     = (state_q == StIssue) &&  wr_q;
        c_addr      = addr_q;
        c_wr_data   = wdata_q;
    end

endmodule
